ag32gbd_sram_arbiter: RTL and testbench
=======================================

Name: ag32gbd_sram_arbiter

Overview:
- Owns the cartridge SRAM bus and shares it between two requesters:
  - the cartridge-side access path (Game Boy reads/writes, already synchronised to sys_clock);
  - the image writer, which dumps captured frame bytes into bank0[000-FFF].
- Sequences every access as a fixed setup/strobe/hold cycle and drives the SRAM control strobes.
- Fixed priority to the cart path, with a starvation guard so the writer always progresses.

Parameters:
ADDR_W, 17, SRAM address width (128 KiB).
STROBE_CYCLES, 2, cycles nWE/nOE held low per access (1..15).
MAX_CART_STREAK, 4, consecutive cart grants allowed while the writer is pending before the writer is forced in (1..15).

Ports:
sys_clock  in  1  sole clock; all logic on its posedge.
sys_resetn  in  1  asynchronous active-low reset.
cart_req  in  1  cart access request; level, held until cart_ack.
cart_we  in  1  1=write, 0=read; sampled at grant.
cart_addr  in  ADDR_W  cart address; sampled at grant.
cart_wdata  in  8  cart write data; sampled at grant.
cart_ack  out  1  one-cycle pulse, access complete.
cart_rdata  out  8  read data; valid while cart_ack=1, holds until the next cart read.
wr_req  in  1  writer request; level, held until wr_ack.
wr_addr  in  12  writer address in bank0; zero-extended to ADDR_W.
wr_data  in  8  writer data.
wr_ack  out  1  one-cycle pulse, write complete.
writer_active  out  1  high from writer grant through its HOLD cycle.
sram_addr  out  ADDR_W  SRAM address.
sram_dout  out  8  SRAM write data.
sram_dout_en  out  1  tristate enable for sram_dout.
sram_din  in  8  SRAM read data.
sram_nCS  out  1  chip select, active low.
sram_nWE  out  1  write strobe, active low.
sram_nOE  out  1  output enable, active low.

Behaviour:
- Reset (async, immediate, also mid-access):
  - sram_nCS=sram_nWE=sram_nOE=1; sram_dout_en=0; sram_addr=0; sram_dout=0.
  - cart_ack=wr_ack=0; cart_rdata=0; writer_active=0.
  - state=IDLE; streak=0.
  - An interrupted access is abandoned and is never acked.
- States: IDLE, SETUP, STROBE, HOLD. An owner register (CART/WRITER) is latched at grant.
- IDLE:
  - Requests are sampled only here.
  - Grant the writer if wr_req && (!cart_req || streak==MAX_CART_STREAK); else grant the cart if cart_req; else stay in IDLE.
  - On grant, latch addr/data/we (writer: we=1) into registers and go to SETUP.
- SETUP (1 cycle): nCS=0; addr driven; for writes, dout and dout_en=1; nWE=nOE=1.
- STROBE (STROBE_CYCLES cycles, counted by a 4-bit counter): nWE=0 for writes or nOE=0 for reads. On the last strobe cycle, a read captures sram_din into cart_rdata.
- HOLD (1 cycle):
  - nWE=nOE=1; nCS=0; addr and dout held (address/data hold past strobe).
  - The owner's ack pulses in this cycle.
  - Next state is IDLE.
- After HOLD: nCS=1 and dout_en=0 in IDLE.
- Latency: grant to ack = STROBE_CYCLES+2 cycles. The minimum gap between accesses is 1 IDLE cycle, so the back-to-back period is STROBE_CYCLES+3.
- Streak counter:
  - +1 (saturating) on each cart grant while wr_req=1.
  - Cleared on writer grant, or in IDLE when wr_req=0.
- Simultaneous requests with streak<MAX: the cart wins.
- A requester that drops its request mid-access: the access completes and the ack still pulses.
- A request still high in the IDLE cycle after its ack is treated as a new request.
- cart_we=1 with a cart address in bank0 is permitted; there is no address protection.
- wr_addr is zero-extended, so writer accesses never leave bank0[000-FFF].
- writer_active is driven from the state/owner registers, not from wr_req.

Test Plan:
1. Reset release; wr_req=1, wr_addr=0x123, wr_data=0xA5 -> SETUP drives sram_addr=0x00123, dout_en=1; nWE low exactly 2 cycles; wr_ack on cycle 4 after grant; nCS high again afterwards.
2. Preload SRAM model 0x1F000=0x3C; cart read -> nOE low 2 cycles; cart_ack with cart_rdata=0x3C; nWE stays high throughout.
3. cart_req and wr_req asserted in the same cycle, both held -> 4 cart grants, then 1 writer grant, then the cart again; wr_ack arrives within 5*(STROBE_CYCLES+3) cycles.
4. sys_resetn pulsed low during STROBE of a write -> nWE/nCS go high asynchronously; no ack is issued; after release the held request restarts from SETUP.
5. wr_req dropped during SETUP -> the write still completes; wr_ack pulses once; no second access.
6. wr_req held continuously with 0x000..0xFFF stepped on each ack -> 4096 acks; SRAM model matches wr_data; no address above 0xFFF is ever driven.

Source files
------------

// File: rtl/ag32gbd_sram_arbiter.sv
// Cartridge SRAM bus owner: arbitrates cart path vs image writer and
// sequences each access as SETUP / STROBE / HOLD with registered strobes.
//
// Ports:
//   sys_clock, sys_resetn             clock, async active-low reset
//   cart_req/we/addr/wdata            cart requester (level until ack)
//   cart_ack, cart_rdata              cart completion pulse, read data
//   wr_req/addr/data                  image writer (bank0, 12-bit addr)
//   wr_ack, writer_active             writer completion, writer owns bus
//   sram_addr/dout/dout_en/din        SRAM address and data bus
//   sram_nCS/nWE/nOE                  SRAM control strobes (active low)
module ag32gbd_sram_arbiter #(
  parameter int ADDR_W          = 17,
  parameter int STROBE_CYCLES   = 2,
  parameter int MAX_CART_STREAK = 4
) (
  input  logic              sys_clock,
  input  logic              sys_resetn,
  input  logic              cart_req,
  input  logic              cart_we,
  input  logic [ADDR_W-1:0] cart_addr,
  input  logic [7:0]        cart_wdata,
  output logic              cart_ack,
  output logic [7:0]        cart_rdata,
  input  logic              wr_req,
  input  logic [11:0]       wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              writer_active,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_dout_en,
  input  logic [7:0]        sram_din,
  output logic              sram_nCS,
  output logic              sram_nWE,
  output logic              sram_nOE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] STRK_MAX  = 4'(MAX_CART_STREAK);

  state_t     state_q;
  logic       own_wr_q;
  logic       we_q;
  logic [3:0] cnt_q;
  logic [3:0] streak_q;
  logic [3:0] streak_d;
  logic       grant_wr_d;
  logic       grant_cart_d;

  // Writer wins when the cart is idle or has used up its streak.
  assign grant_wr_d   = wr_req &&
                        (!cart_req || streak_q == STRK_MAX);
  assign grant_cart_d = cart_req && !grant_wr_d;

  always_comb begin
    streak_d = streak_q;
    if (grant_wr_d || !wr_req) begin
      streak_d = '0;
    end else if (grant_cart_d && streak_q != 4'hF) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q       <= S_IDLE;
      own_wr_q      <= 1'b0;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      streak_q      <= '0;
      cart_ack      <= 1'b0;
      wr_ack        <= 1'b0;
      cart_rdata    <= '0;
      writer_active <= 1'b0;
      sram_addr     <= '0;
      sram_dout     <= '0;
      sram_dout_en  <= 1'b0;
      sram_nCS      <= 1'b1;
      sram_nWE      <= 1'b1;
      sram_nOE      <= 1'b1;
    end else begin
      cart_ack <= 1'b0;
      wr_ack   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          streak_q <= streak_d;
          if (grant_wr_d) begin
            own_wr_q      <= 1'b1;
            we_q          <= 1'b1;
            sram_addr     <= ADDR_W'(wr_addr);
            sram_dout     <= wr_data;
            sram_dout_en  <= 1'b1;
            sram_nCS      <= 1'b0;
            writer_active <= 1'b1;
            state_q       <= S_SETUP;
          end else if (grant_cart_d) begin
            own_wr_q     <= 1'b0;
            we_q         <= cart_we;
            sram_addr    <= cart_addr;
            sram_dout    <= cart_wdata;
            sram_dout_en <= cart_we;
            sram_nCS     <= 1'b0;
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_q    <= '0;
          sram_nWE <= !we_q;
          sram_nOE <= we_q;
          state_q  <= S_STROBE;
        end
        S_STROBE: begin
          if (cnt_q == STRB_LAST) begin
            sram_nWE <= 1'b1;
            sram_nOE <= 1'b1;
            state_q  <= S_HOLD;
            if (own_wr_q) begin
              wr_ack <= 1'b1;
            end else begin
              cart_ack <= 1'b1;
            end
            // Sample read data at the end of the last strobe cycle.
            if (!we_q) begin
              cart_rdata <= sram_din;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_HOLD: begin
          sram_nCS      <= 1'b1;
          sram_dout_en  <= 1'b0;
          writer_active <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ag32gbd_sram_arbiter.sv
// Self-checking bench for ag32gbd_sram_arbiter: access-offset reference
// model, SRAM device model and directed scenarios.
module tb_ag32gbd_sram_arbiter;
  localparam int AW = 17;
  localparam int S  = 2;
  localparam int M  = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cart_req = 1'b0;
  logic          cart_we = 1'b0;
  logic [AW-1:0] cart_addr = '0;
  logic [7:0]    cart_wdata = '0;
  logic          cart_ack;
  logic [7:0]    cart_rdata;
  logic          wr_req = 1'b0;
  logic [11:0]   wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_ack;
  logic          writer_active;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_dout;
  logic          sram_dout_en;
  logic [7:0]    sram_din;
  logic          sram_nCS;
  logic          sram_nWE;
  logic          sram_nOE;

  int nchecks = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ag32gbd_sram_arbiter #(
    .ADDR_W(AW),
    .STROBE_CYCLES(S),
    .MAX_CART_STREAK(M)
  ) dut (
    .sys_clock(clk),
    .sys_resetn(rstn),
    .cart_req(cart_req),
    .cart_we(cart_we),
    .cart_addr(cart_addr),
    .cart_wdata(cart_wdata),
    .cart_ack(cart_ack),
    .cart_rdata(cart_rdata),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .writer_active(writer_active),
    .sram_addr(sram_addr),
    .sram_dout(sram_dout),
    .sram_dout_en(sram_dout_en),
    .sram_din(sram_din),
    .sram_nCS(sram_nCS),
    .sram_nWE(sram_nWE),
    .sram_nOE(sram_nOE)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  // Preload port shared by the device and reference memories.
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;

  // SRAM device: written by the DUT's strobes, read combinationally.
  logic [7:0] dev_mem [0:(1<<AW)-1];
  assign sram_din = dev_mem[sram_addr];
  always @(negedge clk) begin
    if (pre_en) dev_mem[pre_addr] = pre_data;
    if (rstn && !sram_nCS && !sram_nWE) dev_mem[sram_addr] = sram_dout;
  end

  // Reference model: k is the cycle offset since the grant edge
  // (0 = idle, 1 = setup, 2..S+1 = strobe, S+2 = hold).
  int            k = 0;
  int            m_streak = 0;
  bit            m_own = 0;
  bit            m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_dout = '0;
  logic [7:0]    m_rdata = '0;
  logic [7:0]    ref_mem [int];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k = 0; m_streak = 0; m_own = 0; m_we = 0;
      m_addr = '0; m_dout = '0; m_rdata = '0;
    end else begin
      if (pre_en) ref_mem[int'(pre_addr)] = pre_data;
      if (k == 0) begin
        if (wr_req && (!cart_req || m_streak == M)) begin
          m_own = 1; m_we = 1; m_addr = AW'(wr_addr);
          m_dout = wr_data; m_streak = 0; k = 1;
        end else if (cart_req) begin
          if (!wr_req) m_streak = 0;
          else if (m_streak < M) m_streak++;
          m_own = 0; m_we = cart_we; m_addr = cart_addr;
          m_dout = cart_wdata; k = 1;
        end else begin
          m_streak = 0;
        end
      end else if (k == S + 1) begin
        if (m_we) ref_mem[int'(m_addr)] = m_dout;
        else m_rdata = ref_mem[int'(m_addr)];
        k = S + 2;
      end else if (k == S + 2) begin
        k = 0;
      end else begin
        k++;
      end
    end
  end

  bit t6 = 0;
  int hi_addr = 0;

  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] a;
    bit strb;
    if (rstn) begin
      strb = (k >= 2) && (k <= S + 1);
      e = {k == S + 2 && !m_own, k == S + 2 && m_own, k != 0 && m_own,
           k == 0, !(strb && m_we), !(strb && !m_we), k != 0 && m_we};
      a = {cart_ack, wr_ack, writer_active, sram_nCS, sram_nWE,
           sram_nOE, sram_dout_en};
      chk("ctrl{cack,wack,wact,nCS,nWE,nOE,den}", 32'(a), 32'(e));
      chk("sram_addr", 32'(sram_addr), 32'(m_addr));
      if (e[0]) chk("sram_dout", 32'(sram_dout), 32'(m_dout));
      chk("cart_rdata", 32'(cart_rdata), 32'(m_rdata));
      if (t6 && !sram_nCS && sram_addr > 17'hFFF) hi_addr++;
    end
  end

  initial begin
    int n;
    int ackn;
    int lo;
    int lo2;
    int cnt;
    logic [7:0] rd;
    logic [AW-1:0] a1;
    logic d1;
    logic [5:0] seq;
    int nack;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({sram_nCS, sram_nWE, sram_nOE, sram_dout_en,
                         cart_ack, wr_ack, writer_active}),
        32'(7'b1110000));
    chk("rst_bus", 32'({sram_addr, sram_dout, cart_rdata}), 32'h0);
    rstn = 1'b1;

    // 1: single writer access.
    @(negedge clk);
    wr_req = 1; wr_addr = 12'h123; wr_data = 8'hA5;
    ackn = 0; lo = 0; a1 = '0; d1 = 0;
    for (n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) begin a1 = sram_addr; d1 = sram_dout_en; end
      if (!sram_nWE) lo++;
      if (wr_ack) begin ackn = n; wr_req = 0; end
      if (n == 6) chk("t1_ncs_after", 32'(sram_nCS), 32'd1);
    end
    chk("t1_setup_addr", 32'(a1), 32'h00123);
    chk("t1_setup_den", 32'(d1), 32'd1);
    chk("t1_nwe_low", 32'(lo), 32'd2);
    chk("t1_ack_cycle", 32'(ackn), 32'd4);

    // 2: cart read of preloaded location.
    pre_addr = 17'h1F000; pre_data = 8'h3C; pre_en = 1;
    repeat (2) @(negedge clk);
    pre_en = 0;
    cart_req = 1; cart_we = 0; cart_addr = 17'h1F000;
    ackn = 0; lo = 0; lo2 = 0; rd = '0;
    for (n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (!sram_nOE) lo++;
      if (!sram_nWE) lo2++;
      if (cart_ack) begin ackn = n; rd = cart_rdata; cart_req = 0; end
    end
    chk("t2_noe_low", 32'(lo), 32'd2);
    chk("t2_nwe_low", 32'(lo2), 32'd0);
    chk("t2_ack_cycle", 32'(ackn), 32'd4);
    chk("t2_rdata", 32'(rd), 32'h3C);

    // 3: simultaneous requests; starvation guard.
    cart_req = 1; cart_we = 1; cart_addr = 17'h1F100; cart_wdata = 8'h11;
    wr_req = 1; wr_addr = 12'h200; wr_data = 8'h22;
    seq = '0; nack = 0; ackn = 0;
    for (n = 1; n <= 40 && nack < 6; n++) begin
      @(negedge clk);
      if (cart_ack) begin seq = {seq[4:0], 1'b0}; nack++; end
      if (wr_ack) begin
        seq = {seq[4:0], 1'b1}; nack++; ackn = n; wr_req = 0;
      end
    end
    cart_req = 0;
    chk("t3_ack_count", 32'(nack), 32'd6);
    chk("t3_grant_order", 32'(seq), 32'(6'b000010));
    chk("t3_wr_latency_ok", 32'(ackn > 0 && ackn <= 5 * (S + 3)), 32'd1);
    repeat (3) @(negedge clk);

    // 4: reset during the strobe of a write.
    wr_req = 1; wr_addr = 12'h456; wr_data = 8'h77;
    cnt = 0;
    while (sram_nWE && cnt < 10) begin @(negedge clk); cnt++; end
    chk("t4_strobe_seen", 32'(sram_nWE), 32'd0);
    #2 rstn = 1'b0;
    #1 chk("t4_async_ctrl", 32'({sram_nWE, sram_nCS, sram_nOE,
                                 sram_dout_en, writer_active, wr_ack}),
           32'(6'b111000));
    nack = 0;
    repeat (2) begin @(negedge clk); if (wr_ack) nack++; end
    chk("t4_no_ack", 32'(nack), 32'd0);
    rstn = 1'b1;
    ackn = 0; a1 = '0; d1 = 0;
    for (n = 1; n <= 10 && ackn == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin a1 = sram_addr; d1 = sram_nCS; end
      if (wr_ack) begin ackn = n; wr_req = 0; end
    end
    chk("t4_restart_addr", 32'(a1), 32'h00456);
    chk("t4_restart_ncs", 32'(d1), 32'd0);
    chk("t4_restart_ack", 32'(ackn), 32'd4);
    @(negedge clk);

    // 5: writer drops its request during SETUP.
    wr_req = 1; wr_addr = 12'h0AB; wr_data = 8'h5A;
    @(negedge clk);
    wr_req = 0;
    lo = (sram_nCS == 1'b0) ? 1 : 0;
    nack = 0;
    repeat (12) begin
      @(negedge clk);
      if (wr_ack) nack++;
      if (!sram_nCS) lo++;
    end
    chk("t5_ack_once", 32'(nack), 32'd1);
    chk("t5_ncs_cycles", 32'(lo), 32'(S + 2));

    // 6: writer sweeps all of bank0.
    t6 = 1;
    wr_req = 1; wr_addr = 12'h000; wr_data = pat(0);
    nack = 0;
    for (n = 0; n < 4096 * (S + 3) + 100 && nack < 4096; n++) begin
      @(negedge clk);
      if (wr_ack) begin
        nack++;
        if (nack == 4096) wr_req = 0;
        else begin wr_addr = 12'(nack); wr_data = pat(nack); end
      end
    end
    wr_req = 0;
    repeat (4) @(negedge clk);
    t6 = 0;
    chk("t6_ack_count", 32'(nack), 32'd4096);
    chk("t6_addr_above_fff", 32'(hi_addr), 32'd0);
    lo = 0;
    for (int i = 0; i < 4096; i++) if (dev_mem[i] !== pat(i)) lo++;
    chk("t6_bank0_contents", 32'(lo), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
